// File: rtl/dc_bsp_pkg.sv
// Shared BSP constants: CSR word offsets, DFH field values and the CSR responder FSM states.
package dc_bsp_pkg;

    localparam int unsigned CSR_DFH      = 0;
    localparam int unsigned CSR_GUID_L   = 1;
    localparam int unsigned CSR_GUID_H   = 2;
    localparam int unsigned CSR_SCRATCH  = 3;
    localparam int unsigned CSR_COUNTERS = 4;

    localparam logic [3:0]  DFH_TYPE_AFU = 4'h1;
    localparam logic [3:0]  DFH_REV      = 4'h0;
    localparam logic [11:0] DFH_ID       = 12'h000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_BURST,
        ST_WR_BURST
    } csr_state_e;

    function automatic logic [63:0] dfh_word(input logic [23:0] next_addr, input logic eol);
        return {DFH_TYPE_AFU, 19'd0, eol, next_addr, DFH_REV, DFH_ID};
    endfunction

endpackage

// File: rtl/mmio64_csr_responder.sv
// Avalon-MM MMIO64 CSR sink: DFH, GUID, scratch and traffic counters with a
// fixed two-stage read pipeline, read/write bursts and write responses.
module mmio64_csr_responder
    import dc_bsp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned BURST_CNT_WIDTH = 4,
    parameter logic [23:0] DFH_NEXT_ADDR   = 24'h0,
    parameter logic        DFH_EOL         = 1'b1,
    parameter logic [63:0] GUID_L          = 64'h0,
    parameter logic [63:0] GUID_H          = 64'h0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_WIDTH-1:0]      address,
    input  logic                       read,
    input  logic                       write,
    input  logic [BURST_CNT_WIDTH-1:0] burstcount,
    input  logic [63:0]                writedata,
    input  logic [7:0]                 byteenable,
    output logic                       waitrequest,
    output logic [63:0]                readdata,
    output logic                       readdatavalid,
    output logic                       writeresponsevalid,
    output logic [1:0]                 response
);

    csr_state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]      burst_addr_q, burst_addr_d;
    logic [BURST_CNT_WIDTH-1:0] beats_left_q, beats_left_d;
    logic                       init_q;

    logic [BURST_CNT_WIDTH-1:0] req_beats;
    logic                       rd_accept;
    logic                       wr_accept;
    logic                       wr_last;
    logic [ADDR_WIDTH-1:0]      wr_addr;
    logic                       issue_valid;
    logic [ADDR_WIDTH-1:0]      issue_addr;
    logic [63:0]                issue_data;
    logic                       counters_clear;

    logic [63:0] scratch_q;
    logic [31:0] rd_count_q;
    logic [31:0] wr_count_q;
    logic        s1_valid_q, s2_valid_q;
    logic [63:0] s1_data_q, s2_data_q;
    logic        wresp_q;

    assign req_beats = (burstcount == '0) ? BURST_CNT_WIDTH'(1) : burstcount;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            burst_addr_q <= '0;
            beats_left_q <= '0;
            init_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            burst_addr_q <= burst_addr_d;
            beats_left_q <= beats_left_d;
            init_q       <= 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        burst_addr_d = burst_addr_q;
        beats_left_d = beats_left_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rd_accept && req_beats != BURST_CNT_WIDTH'(1)) begin
                    state_d      = ST_RD_BURST;
                    burst_addr_d = address + ADDR_WIDTH'(1);
                    beats_left_d = req_beats - BURST_CNT_WIDTH'(1);
                end else if (wr_accept && !wr_last) begin
                    state_d      = ST_WR_BURST;
                    burst_addr_d = address;
                    beats_left_d = req_beats - BURST_CNT_WIDTH'(1);
                end
            end
            ST_RD_BURST: begin
                burst_addr_d = burst_addr_q + ADDR_WIDTH'(1);
                beats_left_d = beats_left_q - BURST_CNT_WIDTH'(1);
                if (beats_left_q == BURST_CNT_WIDTH'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_BURST: begin
                if (wr_accept) begin
                    burst_addr_d = burst_addr_q + ADDR_WIDTH'(1);
                    beats_left_d = beats_left_q - BURST_CNT_WIDTH'(1);
                    if (wr_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The first write beat lands at the command address; data beats that follow
    // in WR_BURST walk from the latched address, starting at offset 0.
    always_comb begin
        waitrequest = init_q || (state_q == ST_RD_BURST);
        rd_accept   = !init_q && read && (state_q == ST_IDLE);
        wr_accept   = !init_q && write &&
                      (((state_q == ST_IDLE) && !read) || (state_q == ST_WR_BURST));
        wr_last     = (state_q == ST_WR_BURST) ? (beats_left_q == BURST_CNT_WIDTH'(1))
                                               : (req_beats == BURST_CNT_WIDTH'(1));
        wr_addr     = (state_q == ST_WR_BURST) ? burst_addr_q : address;
        issue_valid = rd_accept || (state_q == ST_RD_BURST);
        issue_addr  = (state_q == ST_RD_BURST) ? burst_addr_q : address;
        response    = 2'b00;
    end

    always_comb begin
        issue_data = '0;
        case (issue_addr)
            ADDR_WIDTH'(CSR_DFH):      issue_data = dfh_word(DFH_NEXT_ADDR, DFH_EOL);
            ADDR_WIDTH'(CSR_GUID_L):   issue_data = GUID_L;
            ADDR_WIDTH'(CSR_GUID_H):   issue_data = GUID_H;
            ADDR_WIDTH'(CSR_SCRATCH):  issue_data = scratch_q;
            ADDR_WIDTH'(CSR_COUNTERS): issue_data = {wr_count_q, rd_count_q};
            default:                   issue_data = '0;
        endcase
    end

    assign counters_clear = wr_accept && (wr_addr == ADDR_WIDTH'(CSR_COUNTERS)) && (|byteenable);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q  <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            if (wr_accept && (wr_addr == ADDR_WIDTH'(CSR_SCRATCH))) begin
                for (int unsigned i = 0; i < 8; i++) begin
                    if (byteenable[i]) begin
                        scratch_q[8*i +: 8] <= writedata[8*i +: 8];
                    end
                end
            end
            // A clear in the same cycle as an increment leaves the counters at zero.
            if (counters_clear) begin
                rd_count_q <= '0;
                wr_count_q <= '0;
            end else begin
                if (rd_accept) begin
                    rd_count_q <= rd_count_q + 32'd1;
                end
                if (wr_accept && wr_last) begin
                    wr_count_q <= wr_count_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            wresp_q    <= 1'b0;
        end else begin
            s1_valid_q <= issue_valid;
            s1_data_q  <= issue_valid ? issue_data : '0;
            s2_valid_q <= s1_valid_q;
            s2_data_q  <= s1_valid_q ? s1_data_q : '0;
            wresp_q    <= wr_accept && wr_last;
        end
    end

    assign readdata           = s2_data_q;
    assign readdatavalid      = s2_valid_q;
    assign writeresponsevalid = wresp_q;

endmodule

// File: tb/tb_mmio64_csr_responder.sv
// Self-checking bench for mmio64_csr_responder: directed vector table, corner
// sequences and randomized traffic against a register-level reference model.
module tb_mmio64_csr_responder;

    localparam logic [63:0] G_L     = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] G_H     = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] DFH_VAL = 64'h1000_0100_1000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] address;
    logic        read;
    logic        write;
    logic [3:0]  burstcount;
    logic [63:0] writedata;
    logic [7:0]  byteenable;
    logic        waitrequest;
    logic [63:0] readdata;
    logic        readdatavalid;
    logic        writeresponsevalid;
    logic [1:0]  response;

    mmio64_csr_responder #(
        .ADDR_WIDTH(16),
        .BURST_CNT_WIDTH(4),
        .DFH_NEXT_ADDR(24'h001000),
        .DFH_EOL(1'b1),
        .GUID_L(G_L),
        .GUID_H(G_H)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .read(read),
        .write(write),
        .burstcount(burstcount),
        .writedata(writedata),
        .byteenable(byteenable),
        .waitrequest(waitrequest),
        .readdata(readdata),
        .readdatavalid(readdatavalid),
        .writeresponsevalid(writeresponsevalid),
        .response(response)
    );

    always #5 clk = ~clk;

    int pcount = 0;
    always @(posedge clk) pcount <= pcount + 1;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } beat_t;

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [3:0]  bc;
        logic [63:0] data;
        logic [7:0]  be;
        logic [63:0] exp;
    } vec_t;

    beat_t exp_rd[$];
    int    exp_wr[$];
    bit    mon_on = 1'b0;
    int    checks = 0;
    int    failures = 0;

    logic [63:0] wd[16];
    logic [7:0]  wbe[16];

    // Reference model: register contents and command counts.
    logic [63:0] m_scratch;
    logic [31:0] m_rd;
    logic [31:0] m_wr;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_scratch = '0;
        m_rd      = '0;
        m_wr      = '0;
    endfunction

    function automatic logic [63:0] model_read(input logic [15:0] a, input logic [31:0] rdc);
        case (a)
            16'd0:   return DFH_VAL;
            16'd1:   return G_L;
            16'd2:   return G_H;
            16'd3:   return m_scratch;
            16'd4:   return {m_wr, rdc};
            default: return 64'd0;
        endcase
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [63:0] d,
                                        input logic [7:0] be, input bit last);
        if (a == 16'd3) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
            end
        end
        if (a == 16'd4 && be != 8'h00) begin
            m_rd = '0;
            m_wr = '0;
        end else if (last) begin
            m_wr = m_wr + 32'd1;
        end
    endfunction

    always @(negedge clk) begin : monitor
        beat_t b;
        bit    rv;
        bit    wv;
        if (mon_on && reset_n) begin
            rv = (exp_rd.size() > 0) && (exp_rd[0].cyc == pcount);
            chk("readdatavalid", 64'(readdatavalid), 64'(rv));
            if (rv) begin
                b = exp_rd.pop_front();
                chk("readdata", readdata, b.data);
                chk("response_rd", 64'(response), 64'd0);
            end
            while (exp_rd.size() > 0 && exp_rd[0].cyc < pcount) void'(exp_rd.pop_front());
            wv = (exp_wr.size() > 0) && (exp_wr[0] == pcount);
            chk("writeresponsevalid", 64'(writeresponsevalid), 64'(wv));
            if (wv) begin
                void'(exp_wr.pop_front());
                chk("response_wr", 64'(response), 64'd0);
            end
            while (exp_wr.size() > 0 && exp_wr[0] < pcount) void'(exp_wr.pop_front());
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (waitrequest !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (waitrequest !== 1'b0) chk("waitrequest_timeout", 64'(waitrequest), 64'd0);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [3:0] bc, input bit use_exp,
                           input logic [63:0] exp0, input string tag);
        int    n;
        int    hi;
        int    p;
        beat_t b;
        logic [15:0] ba;
        wait_ready();
        n = (bc == 4'd0) ? 1 : int'(bc);
        p = pcount + 1;
        for (int j = 0; j < n; j++) begin
            ba     = a + 16'(j);
            b.cyc  = p + j + 1;
            b.data = (j == 0 && use_exp) ? exp0 : model_read(ba, (j == 0) ? m_rd : m_rd + 32'd1);
            exp_rd.push_back(b);
        end
        read       = 1'b1;
        address    = a;
        burstcount = bc;
        @(posedge clk);
        m_rd = m_rd + 32'd1;
        @(negedge clk);
        read = 1'b0;
        hi = 0;
        while (waitrequest === 1'b1 && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        chk({tag, "_waitrequest_cycles"}, 64'(hi), 64'(n - 1));
    endtask

    task automatic do_write(input logic [15:0] a, input logic [3:0] bc, input string tag);
        int n;
        logic [15:0] ba;
        wait_ready();
        n = (bc == 4'd0) ? 1 : int'(bc);
        for (int k = 0; k < n; k++) begin
            if (k > 0) chk({tag, "_burst_waitrequest"}, 64'(waitrequest), 64'd0);
            write      = 1'b1;
            address    = a;
            burstcount = bc;
            writedata  = wd[k];
            byteenable = wbe[k];
            if (k == n - 1) exp_wr.push_back(pcount + 1);
            @(posedge clk);
            ba = (k == 0) ? a : a + 16'(k - 1);
            model_write(ba, wd[k], wbe[k], k == n - 1);
            @(negedge clk);
        end
        write = 1'b0;
    endtask

    task automatic write1(input logic [15:0] a, input logic [63:0] d, input logic [7:0] be);
        wd[0]  = d;
        wbe[0] = be;
        do_write(a, 4'd1, "wr1");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t  tbl[18];
        beat_t b;
        int    stale;

        read = 1'b0; write = 1'b0; address = '0; burstcount = 4'd1;
        writedata = '0; byteenable = '0;
        model_reset();

        tbl[0]  = '{1'b0, 16'd0, 4'd1, 64'h0, 8'h00, DFH_VAL};
        tbl[1]  = '{1'b0, 16'd1, 4'd0, 64'h0, 8'h00, G_L};
        tbl[2]  = '{1'b0, 16'd2, 4'd1, 64'h0, 8'h00, G_H};
        tbl[3]  = '{1'b0, 16'd3, 4'd1, 64'h0, 8'h00, 64'h0};
        tbl[4]  = '{1'b0, 16'd4, 4'd1, 64'h0, 8'h00, 64'h0000_0000_0000_0004};
        tbl[5]  = '{1'b1, 16'd3, 4'd1, 64'hDEAD_BEEF_0123_4567, 8'h0F, 64'h0};
        tbl[6]  = '{1'b0, 16'd3, 4'd1, 64'h0, 8'h00, 64'h0000_0000_0123_4567};
        tbl[7]  = '{1'b1, 16'd3, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 64'h0};
        tbl[8]  = '{1'b0, 16'd3, 4'd1, 64'h0, 8'h00, 64'hFFFF_FFFF_0123_4567};
        tbl[9]  = '{1'b1, 16'd7, 4'd1, 64'h1111_2222_3333_4444, 8'hFF, 64'h0};
        tbl[10] = '{1'b0, 16'd7, 4'd1, 64'h0, 8'h00, 64'h0};
        tbl[11] = '{1'b0, 16'd4, 4'd1, 64'h0, 8'h00, 64'h0000_0003_0000_0008};
        tbl[12] = '{1'b1, 16'd4, 4'd1, 64'h0, 8'h01, 64'h0};
        tbl[13] = '{1'b0, 16'd4, 4'd1, 64'h0, 8'h00, 64'h0};
        tbl[14] = '{1'b1, 16'd4, 4'd1, 64'hFFFF, 8'h00, 64'h0};
        tbl[15] = '{1'b0, 16'd4, 4'd1, 64'h0, 8'h00, 64'h0000_0001_0000_0001};
        tbl[16] = '{1'b1, 16'd3, 4'd0, 64'h5555, 8'h00, 64'h0};
        tbl[17] = '{1'b0, 16'd3, 4'd1, 64'h0, 8'h00, 64'hFFFF_FFFF_0123_4567};

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_waitrequest", 64'(waitrequest), 64'd1);
        chk("reset_readdatavalid", 64'(readdatavalid), 64'd0);
        chk("reset_writeresponsevalid", 64'(writeresponsevalid), 64'd0);
        chk("reset_readdata", readdata, 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("waitrequest_first_cycle", 64'(waitrequest), 64'd1);
        @(negedge clk);
        chk("waitrequest_after_init", 64'(waitrequest), 64'd0);
        mon_on = 1'b1;

        foreach (tbl[i]) begin
            if (tbl[i].is_wr) begin
                wd[0]  = tbl[i].data;
                wbe[0] = tbl[i].be;
                do_write(tbl[i].addr, tbl[i].bc, "tbl_wr");
            end else begin
                do_read(tbl[i].addr, tbl[i].bc, 1'b1, tbl[i].exp, "tbl_rd");
            end
        end

        // Read burst of 4 from GUID_L: one command counted.
        write1(16'd4, 64'h0, 8'hFF);
        do_read(16'd1, 4'd4, 1'b0, 64'h0, "burst4");
        do_read(16'd4, 4'd1, 1'b1, 64'h0000_0000_0000_0001, "burst4_count");

        // Write burst of 2 at SCRATCH: second beat rewrites SCRATCH.
        write1(16'd4, 64'h0, 8'hFF);
        wd[0] = 64'hAAAA_0000_AAAA_0000; wbe[0] = 8'hFF;
        wd[1] = 64'hBBBB_1111_BBBB_1111; wbe[1] = 8'hFF;
        do_write(16'd3, 4'd2, "wburst2");
        do_read(16'd3, 4'd1, 1'b1, 64'hBBBB_1111_BBBB_1111, "wburst2_scratch");
        do_read(16'd4, 4'd1, 1'b1, 64'h0000_0001_0000_0001, "wburst2_count");

        // 5 reads, 3 writes, then clear.
        write1(16'd4, 64'h0, 8'hFF);
        repeat (5) do_read(16'd0, 4'd1, 1'b1, DFH_VAL, "cnt_rd");
        repeat (3) write1(16'd5, 64'h1234, 8'hFF);
        do_read(16'd4, 4'd1, 1'b1, 64'h0000_0003_0000_0005, "cnt_before_clear");
        write1(16'd4, 64'h0, 8'h80);
        do_read(16'd4, 4'd1, 1'b1, 64'h0, "cnt_after_clear");

        // Address wrap at the top of the word space.
        do_read(16'hFFFE, 4'd4, 1'b0, 64'h0, "wrap");

        // Reset during the third beat of an 8-beat burst.
        wait_ready();
        b.cyc  = pcount + 2;
        b.data = DFH_VAL;
        exp_rd.push_back(b);
        read = 1'b1; address = 16'd0; burstcount = 4'd8;
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        model_reset();
        #1;
        chk("midreset_readdatavalid", 64'(readdatavalid), 64'd0);
        chk("midreset_waitrequest", 64'(waitrequest), 64'd1);
        chk("midreset_readdata", readdata, 64'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (readdatavalid) stale++;
        end
        chk("midreset_stale_beats", 64'(stale), 64'd0);
        do_read(16'd2, 4'd1, 1'b1, G_H, "post_reset");
        do_read(16'd3, 4'd1, 1'b1, 64'h0, "post_reset_scratch");
        do_read(16'd4, 4'd1, 1'b1, 64'h0000_0000_0000_0002, "post_reset_count");

        for (int i = 0; i < 250; i++) begin
            logic [15:0] a;
            logic [3:0]  bc;
            a = ($urandom_range(0, 9) < 8) ? 16'($urandom_range(0, 6)) : 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                bc = 4'($urandom_range(0, 15));
                do_read(a, bc, 1'b0, 64'h0, "rnd_rd");
            end else begin
                bc = 4'($urandom_range(0, 3));
                for (int k = 0; k < 4; k++) begin
                    wd[k]  = {$urandom, $urandom};
                    wbe[k] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                end
                do_write(a, bc, "rnd_wr");
            end
        end

        repeat (6) @(negedge clk);
        chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
        chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
